dm_bus_arbiter: RTL and testbench
=================================

Name: dm_bus_arbiter

Overview:
Two-master arbiter for the shared data memory port: word-addressed, byte-enabled, combinational read, write on posedge.
- Master 0 is the CPU M-stage data port.
- Master 1 is a DMA/loader engine with optional locked bursts.
- Arbitration is round-robin, with an owner state machine, burst limiting, out-of-range trapping and a CPU stall output.

Parameters:
DM_WORDS, 4096, number of 32-bit words in data memory; word index >= DM_WORDS is out of range.
MAX_BURST, 4, maximum consecutive master-1 beats held by m1_lock while master 0 is requesting (>=1).

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
m0_req  input  1  CPU access request; held with addr/wdata/byteen stable until m0_ack.
m0_addr  input  32  CPU byte address.
m0_wdata  input  32  CPU write data, byte lanes pre-aligned.
m0_byteen  input  4  CPU byte write enables; 0 = read.
m0_ack  output  1  access performed this cycle.
m0_rdata  output  32  read data, valid while m0_ack.
m0_err  output  1  out-of-range access acknowledged this cycle.
m0_stall  output  1  m0_req & ~m0_ack; freezes CPU pipeline.
m1_req, m1_addr, m1_wdata, m1_byteen, m1_ack, m1_rdata, m1_err  as m0_*, for master 1.
m1_lock  input  1  request to keep grant for the following beat.
mem_addr  output  32  to memory: granted address & 32'hfffffffc.
mem_wdata  output  32  to memory: granted write data.
mem_byteen  output  4  to memory: granted byteen; 0 when no valid write.
mem_rdata  input  32  from memory, combinational on mem_addr.
owner  output  2  status: 0 idle, 1 master 0, 2 master 1.

Behaviour:
Reset (reset=0, asynchronous):
- state=IDLE, last_owner=1 (so master 0 wins the first tie), burst_cnt=0.
- All acks/errs=0, mem_addr=0, mem_wdata=0, mem_byteen=0, rdatas=0, owner=0, m0_stall=m0_req.
- Reset mid-transaction drops the transaction; no write occurs.

States IDLE, GNT0, GNT1.
- In GNTx, mem_* are driven combinationally from master x.
- ack_x = req_x in GNTx.
- The non-owner's ack, err and rdata are 0.
- IDLE: mem_byteen=0, no acks.

Latency:
- Request seen at posedge N gives ack in cycle N+1 at the earliest.
- Writes commit at the posedge ending the ack cycle.

Out of range (addr>>2 >= DM_WORDS):
- ack=1, err=1, rdata=0, mem_byteen forced 0.

Dropped request: if req_x falls while in GNTx, there is no ack and mem_byteen=0; the beat counts as completed.

Transitions (posedge):
- IDLE:
  - both requesting: grant to the master != last_owner.
  - one requesting: grant to it.
  - none: stay IDLE.
- GNT0 completing: last_owner<=0; m1_req -> GNT1; else m0_req is masked this edge -> IDLE.
- GNT1 completing, last_owner<=1:
  - stay GNT1 with burst_cnt+1 (saturating) if m1_lock & m1_req & (burst_cnt < MAX_BURST-1 | ~m0_req);
  - else m0_req -> GNT0, burst_cnt<=0;
  - else -> IDLE, burst_cnt<=0.
- burst_cnt clears on entering GNT1 from any other state.
- Without m1_lock, a master never gets two consecutive beats when the other is requesting.
- A lone master 0 alternates GNT0/IDLE, so its throughput is one access per 2 cycles.

Simultaneous events:
- A request arriving in the same cycle as another master's ack is arbitrated at that posedge.
- Master 0's own new request after ack is seen one cycle later.

Test Plan:
- m0 read 0x00000010 with mem word 4 = 0xdeadbeef, m1 idle -> owner=1 next cycle; m0_ack=1, m0_rdata=0xdeadbeef; m0_stall high for 1 cycle.
- Both req from IDLE after reset, m0 write 0x20 byteen=4'b0011 wdata=0x1234abcd, m1 read 0x24 -> GNT0 first; mem_byteen=0011, mem_addr=0x20; then GNT1 with m1_ack.
- m1_lock=1 with 8 beats while m0_req held -> exactly 4 m1 beats, then 1 m0 beat, then m1 resumes; burst_cnt resets.
- m1_lock=1 with 6 beats, m0 idle -> 6 consecutive m1_acks with no IDLE gaps.
- m0 write addr 0x00004000 (word 4096) byteen=1111 -> m0_ack=1, m0_err=1, mem_byteen=0000; memory unchanged.
- Assert reset=0 asynchronously mid-GNT1 write -> outputs zero immediately, no write; after release m0 wins the first tie.

Source files
------------

// File: rtl/dm_bus_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and the memory port.
// slave = arbiter side, master = requester/memory side.
interface dm_bus_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_byteen;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m0_err;
    logic        m0_stall;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_byteen;
    logic        m1_lock;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_rdata;
    logic [1:0]  owner;

    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_byteen,
        input  m1_req, m1_addr, m1_wdata, m1_byteen, m1_lock,
        input  mem_rdata,
        output m0_ack, m0_rdata, m0_err, m0_stall,
        output m1_ack, m1_rdata, m1_err,
        output mem_addr, mem_wdata, mem_byteen, owner
    );

    modport master (
        output m0_req, m0_addr, m0_wdata, m0_byteen,
        output m1_req, m1_addr, m1_wdata, m1_byteen, m1_lock,
        output mem_rdata,
        input  m0_ack, m0_rdata, m0_err, m0_stall,
        input  m1_ack, m1_rdata, m1_err,
        input  mem_addr, mem_wdata, mem_byteen, owner
    );
endinterface

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter: CPU (master 0) and DMA (master 1, lockable bursts) share
// one word-addressed data memory port with combinational read.
//
// state | meaning
// IDLE  | no grant; memory port quiet
// GNT0  | master 0 owns the port this cycle
// GNT1  | master 1 owns the port; burst_cnt counts extra locked beats
module dm_bus_arbiter #(
    parameter int DM_WORDS  = 4096,
    parameter int MAX_BURST = 4
) (
    input logic             clk,
    input logic             reset,
    dm_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    localparam int            BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [31:0]   WORD_LIMIT = 32'(DM_WORDS);

    state_t        state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;

    logic        m0_oor, m1_oor;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_byteen;

    assign m0_oor = {2'b00, bus.m0_addr[31:2]} >= WORD_LIMIT;
    assign m1_oor = {2'b00, bus.m1_addr[31:2]} >= WORD_LIMIT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.m0_req && (!bus.m1_req || last_owner_q)) begin
                    state_d = GNT0;
                end else if (bus.m1_req) begin
                    state_d     = GNT1;
                    burst_cnt_d = '0;
                end
            end
            GNT0: begin
                // m0's next request is deliberately not considered on this edge
                last_owner_d = 1'b0;
                if (bus.m1_req) begin
                    state_d     = GNT1;
                    burst_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                last_owner_d = 1'b1;
                if (bus.m1_lock && bus.m1_req && (burst_cnt_q < BURST_LAST || !bus.m0_req)) begin
                    if (burst_cnt_q != BURST_LAST) burst_cnt_d = burst_cnt_q + 1'b1;
                end else begin
                    burst_cnt_d = '0;
                    state_d     = bus.m0_req ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m0_ack     = 1'b0;
        m0_err     = 1'b0;
        m0_rdata   = '0;
        m1_ack     = 1'b0;
        m1_err     = 1'b0;
        m1_rdata   = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_byteen = '0;
        case (state_q)
            GNT0: begin
                mem_addr   = bus.m0_addr & 32'hffff_fffc;
                mem_wdata  = bus.m0_wdata;
                mem_byteen = (bus.m0_req && !m0_oor) ? bus.m0_byteen : 4'b0000;
                m0_ack     = bus.m0_req;
                m0_err     = bus.m0_req && m0_oor;
                m0_rdata   = (bus.m0_req && !m0_oor) ? bus.mem_rdata : 32'h0;
            end
            GNT1: begin
                mem_addr   = bus.m1_addr & 32'hffff_fffc;
                mem_wdata  = bus.m1_wdata;
                mem_byteen = (bus.m1_req && !m1_oor) ? bus.m1_byteen : 4'b0000;
                m1_ack     = bus.m1_req;
                m1_err     = bus.m1_req && m1_oor;
                m1_rdata   = (bus.m1_req && !m1_oor) ? bus.mem_rdata : 32'h0;
            end
            default: ;
        endcase
    end

    assign bus.m0_ack     = m0_ack;
    assign bus.m0_err     = m0_err;
    assign bus.m0_rdata   = m0_rdata;
    assign bus.m0_stall   = bus.m0_req & ~m0_ack;
    assign bus.m1_ack     = m1_ack;
    assign bus.m1_err     = m1_err;
    assign bus.m1_rdata   = m1_rdata;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_byteen = mem_byteen;
    assign bus.owner      = state_q;
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench for dm_bus_arbiter with a 4096-word byte-enabled memory model.
module tb_dm_bus_arbiter;
    logic clk;
    logic reset;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    dm_bus_arbiter_if bus ();

    dm_bus_arbiter #(.DM_WORDS(4096), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:4095];
    logic [3:0]  wr_be = 4'b0000;
    logic [11:0] wr_idx = '0;
    logic [31:0] wr_data = '0;

    assign bus.mem_rdata = mem[bus.mem_addr[13:2]];

    // Capture the write mid-cycle, commit it on the edge that ends the cycle.
    always @(negedge clk) begin
        wr_be   = bus.mem_byteen;
        wr_idx  = bus.mem_addr[13:2];
        wr_data = bus.mem_wdata;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (wr_be[k]) mem[wr_idx][8*k +: 8] = wr_data[8*k +: 8];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_inputs();
        bus.m0_req = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_byteen = 0;
        bus.m1_req = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_byteen = 0; bus.m1_lock = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clr_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clr_inputs();
        bus.m0_req = 1; bus.m0_addr = 32'h10;
        bus.m1_req = 1; bus.m1_addr = 32'h24;
        next_cycle();
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL rst_owner got %0d exp 0", bus.owner); end
        vec_cnt++; if ({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 4'b0) begin err_cnt++; $display("FAIL rst_ack_err got %b exp 0000", {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}); end
        vec_cnt++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_byteen} !== 68'h0) begin err_cnt++; $display("FAIL rst_mem got %h/%h/%b exp 0", bus.mem_addr, bus.mem_wdata, bus.mem_byteen); end
        vec_cnt++; if (bus.m0_stall !== 1'b1) begin err_cnt++; $display("FAIL rst_stall got %b exp 1", bus.m0_stall); end
        vec_cnt++; if ({bus.m0_rdata, bus.m1_rdata} !== 64'h0) begin err_cnt++; $display("FAIL rst_rdata got %h/%h exp 0", bus.m0_rdata, bus.m1_rdata); end
        clr_inputs();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_m0_read();
        next_cycle();
        bus.m0_req = 1; bus.m0_addr = 32'h10; bus.m0_byteen = 4'b0000;
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL rd_owner_idle got %0d exp 0", bus.owner); end
        vec_cnt++; if (bus.m0_stall !== 1'b1) begin err_cnt++; $display("FAIL rd_stall_wait got %b exp 1", bus.m0_stall); end
        next_cycle();
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd1) begin err_cnt++; $display("FAIL rd_owner got %0d exp 1", bus.owner); end
        vec_cnt++; if (bus.m0_ack !== 1'b1) begin err_cnt++; $display("FAIL rd_ack got %b exp 1", bus.m0_ack); end
        vec_cnt++; if (bus.m0_rdata !== 32'hdeadbeef) begin err_cnt++; $display("FAIL rd_rdata got %h exp deadbeef", bus.m0_rdata); end
        vec_cnt++; if (bus.m0_stall !== 1'b0) begin err_cnt++; $display("FAIL rd_stall_ack got %b exp 0", bus.m0_stall); end
        next_cycle();
        bus.m0_req = 0;
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL rd_owner_after got %0d exp 0", bus.owner); end
    endtask

    task automatic test_both_req();
        do_reset();
        next_cycle();
        bus.m0_req = 1; bus.m0_addr = 32'h20; bus.m0_wdata = 32'h1234abcd; bus.m0_byteen = 4'b0011;
        bus.m1_req = 1; bus.m1_addr = 32'h24; bus.m1_byteen = 4'b0000;
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL both_idle got %0d exp 0", bus.owner); end
        next_cycle();
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd1) begin err_cnt++; $display("FAIL both_first got %0d exp 1", bus.owner); end
        vec_cnt++; if (bus.mem_byteen !== 4'b0011) begin err_cnt++; $display("FAIL both_byteen got %b exp 0011", bus.mem_byteen); end
        vec_cnt++; if (bus.mem_addr !== 32'h20) begin err_cnt++; $display("FAIL both_addr got %h exp 00000020", bus.mem_addr); end
        vec_cnt++; if ({bus.m0_ack, bus.m1_ack} !== 2'b10) begin err_cnt++; $display("FAIL both_acks0 got %b exp 10", {bus.m0_ack, bus.m1_ack}); end
        next_cycle();
        bus.m0_req = 0;
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd2) begin err_cnt++; $display("FAIL both_second got %0d exp 2", bus.owner); end
        vec_cnt++; if ({bus.m0_ack, bus.m1_ack} !== 2'b01) begin err_cnt++; $display("FAIL both_acks1 got %b exp 01", {bus.m0_ack, bus.m1_ack}); end
        vec_cnt++; if (bus.m1_rdata !== 32'hcafef00d) begin err_cnt++; $display("FAIL both_m1_rdata got %h exp cafef00d", bus.m1_rdata); end
        vec_cnt++; if (mem[8] !== 32'hffffabcd) begin err_cnt++; $display("FAIL both_write got %h exp ffffabcd", mem[8]); end
        next_cycle();
        bus.m1_req = 0;
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL both_end got %0d exp 0", bus.owner); end
    endtask

    task automatic test_lock_burst();
        logic [1:0] exp_own [9] = '{2, 2, 2, 2, 1, 2, 2, 2, 2};
        int m1_beats = 0;
        next_cycle();
        bus.m1_req = 1; bus.m1_lock = 1; bus.m1_addr = 32'h100; bus.m1_byteen = 0;
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL lk_idle got %0d exp 0", bus.owner); end
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            if (i == 0) begin bus.m0_req = 1; bus.m0_addr = 32'h40; bus.m0_byteen = 0; end
            if (i == 5) bus.m0_req = 0;
            if (i == 8) bus.m1_lock = 0;
            @(negedge clk);
            if (bus.m1_ack === 1'b1) m1_beats++;
            vec_cnt++; if (bus.owner !== exp_own[i]) begin err_cnt++; $display("FAIL lk_owner[%0d] got %0d exp %0d", i, bus.owner, exp_own[i]); end
            vec_cnt++; if ({bus.m0_ack, bus.m1_ack} !== {exp_own[i] == 2'd1, exp_own[i] == 2'd2}) begin err_cnt++; $display("FAIL lk_acks[%0d] got %b exp %b", i, {bus.m0_ack, bus.m1_ack}, {exp_own[i] == 2'd1, exp_own[i] == 2'd2}); end
            if (i < 4) begin
                vec_cnt++; if (bus.m0_stall !== 1'b1) begin err_cnt++; $display("FAIL lk_stall[%0d] got %b exp 1", i, bus.m0_stall); end
            end
        end
        next_cycle();
        bus.m1_req = 0;
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL lk_end got %0d exp 0", bus.owner); end
        vec_cnt++; if (m1_beats !== 8) begin err_cnt++; $display("FAIL lk_beats got %0d exp 8", m1_beats); end
    endtask

    task automatic test_lock_nogap();
        next_cycle();
        bus.m1_req = 1; bus.m1_lock = 1; bus.m1_byteen = 4'b1111;
        bus.m1_addr = 32'h190; bus.m1_wdata = 32'h100;
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL ng_idle got %0d exp 0", bus.owner); end
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            if (i > 0) begin bus.m1_addr = 32'h190 + 32'(4 * i); bus.m1_wdata = 32'h100 + 32'(i); end
            if (i == 5) bus.m1_lock = 0;
            @(negedge clk);
            vec_cnt++; if ({bus.owner, bus.m1_ack} !== 3'b101) begin err_cnt++; $display("FAIL ng_beat[%0d] got owner %0d ack %b exp owner 2 ack 1", i, bus.owner, bus.m1_ack); end
        end
        next_cycle();
        bus.m1_req = 0; bus.m1_byteen = 0;
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL ng_end got %0d exp 0", bus.owner); end
        for (int i = 0; i < 6; i++) begin
            vec_cnt++; if (mem[100 + i] !== 32'h100 + 32'(i)) begin err_cnt++; $display("FAIL ng_mem[%0d] got %h exp %h", 100 + i, mem[100 + i], 32'h100 + 32'(i)); end
        end
    endtask

    task automatic test_out_of_range();
        next_cycle();
        bus.m0_req = 1; bus.m0_addr = 32'h4000; bus.m0_wdata = 32'h77777777; bus.m0_byteen = 4'b1111;
        next_cycle();
        @(negedge clk);
        vec_cnt++; if ({bus.m0_ack, bus.m0_err} !== 2'b11) begin err_cnt++; $display("FAIL oor_ack_err got %b exp 11", {bus.m0_ack, bus.m0_err}); end
        vec_cnt++; if (bus.mem_byteen !== 4'b0000) begin err_cnt++; $display("FAIL oor_byteen got %b exp 0000", bus.mem_byteen); end
        vec_cnt++; if (bus.m0_rdata !== 32'h0) begin err_cnt++; $display("FAIL oor_rdata got %h exp 0", bus.m0_rdata); end
        next_cycle();
        bus.m0_req = 0;
        @(negedge clk);
        vec_cnt++; if (mem[0] !== 32'h11111111) begin err_cnt++; $display("FAIL oor_mem got %h exp 11111111", mem[0]); end
        next_cycle();
        bus.m0_req = 1; bus.m0_addr = 32'h3ffc; bus.m0_byteen = 4'b0000;
        next_cycle();
        @(negedge clk);
        vec_cnt++; if ({bus.m0_ack, bus.m0_err} !== 2'b10) begin err_cnt++; $display("FAIL top_ack_err got %b exp 10", {bus.m0_ack, bus.m0_err}); end
        vec_cnt++; if (bus.m0_rdata !== 32'h0badcafe) begin err_cnt++; $display("FAIL top_rdata got %h exp 0badcafe", bus.m0_rdata); end
        next_cycle();
        bus.m0_req = 0;
    endtask

    task automatic test_reset_mid_write();
        next_cycle();
        bus.m1_req = 1; bus.m1_lock = 0; bus.m1_addr = 32'h320; bus.m1_wdata = 32'ha5a5a5a5; bus.m1_byteen = 4'b1111;
        next_cycle();
        bus.m0_req = 1; bus.m0_addr = 32'h10; bus.m0_byteen = 4'b0000;
        #1;
        reset = 1'b0;
        #1;
        vec_cnt++; if ({bus.owner, bus.m1_ack, bus.m0_ack} !== 4'b0) begin err_cnt++; $display("FAIL mid_owner_ack got %0d/%b/%b exp 0/0/0", bus.owner, bus.m1_ack, bus.m0_ack); end
        vec_cnt++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_byteen} !== 68'h0) begin err_cnt++; $display("FAIL mid_mem got %h/%h/%b exp 0", bus.mem_addr, bus.mem_wdata, bus.mem_byteen); end
        vec_cnt++; if (bus.m0_stall !== 1'b1) begin err_cnt++; $display("FAIL mid_stall got %b exp 1", bus.m0_stall); end
        next_cycle();
        vec_cnt++; if (mem[200] !== 32'h0) begin err_cnt++; $display("FAIL mid_nowrite got %h exp 0", mem[200]); end
        #1;
        reset = 1'b1;
        @(negedge clk);
        vec_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL mid_idle got %0d exp 0", bus.owner); end
        next_cycle();
        @(negedge clk);
        vec_cnt++; if ({bus.owner, bus.m0_ack} !== 3'b011) begin err_cnt++; $display("FAIL mid_tie got owner %0d ack %b exp owner 1 ack 1", bus.owner, bus.m0_ack); end
        next_cycle();
        bus.m0_req = 0;
        @(negedge clk);
        vec_cnt++; if ({bus.owner, bus.m1_ack} !== 3'b101) begin err_cnt++; $display("FAIL mid_m1 got owner %0d ack %b exp owner 2 ack 1", bus.owner, bus.m1_ack); end
        next_cycle();
        bus.m1_req = 0; bus.m1_byteen = 0;
        @(negedge clk);
        vec_cnt++; if (mem[200] !== 32'ha5a5a5a5) begin err_cnt++; $display("FAIL mid_write got %h exp a5a5a5a5", mem[200]); end
        vec_cnt++; if (bus.owner !== 2'd0) begin err_cnt++; $display("FAIL mid_end got %0d exp 0", bus.owner); end
    endtask

    initial begin
        reset = 1'b0;
        clr_inputs();
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0]    = 32'h11111111;
        mem[4]    = 32'hdeadbeef;
        mem[8]    = 32'hffffffff;
        mem[9]    = 32'hcafef00d;
        mem[4095] = 32'h0badcafe;
        test_reset();
        test_m0_read();
        test_both_req();
        test_lock_burst();
        test_lock_nogap();
        test_out_of_range();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
